// File: rtl/and_gate_tester.sv
// Exhaustive sweep tester for a quad 2-input AND gate: drives all 256 {A,B} vectors,
// waits SETTLE cycles per vector and compares Y. Optional macro: TESTER_STOP_ON_FAIL_EN.
module and_gate_tester #(
  parameter int SETTLE = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic [3:0] Y,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [8:0] ERR_CNT,
  output logic [7:0] FAIL_VEC
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_FIN    = 2'd3;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  logic [1:0] state_q, state_d;
  logic [7:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [8:0] err_cnt_q, err_cnt_d;
  logic [7:0] fail_vec_q, fail_vec_d;
  logic       first_fail_q, first_fail_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       mismatch;

  // {A,B} is the vector register itself, so the gate inputs are always registered
  assign mismatch = (Y != (vec_q[7:4] & vec_q[3:0]));

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    err_cnt_d    = err_cnt_q;
    fail_vec_d   = fail_vec_q;
    first_fail_d = first_fail_q;

    case (state_q)
      S_IDLE, S_FIN: begin
        if (START) begin
          state_d      = S_SETTLE;
          vec_d        = 8'h00;
          cnt_d        = SETTLE_LD;
          err_cnt_d    = 9'd0;
          fail_vec_d   = 8'h00;
          first_fail_d = 1'b0;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          err_cnt_d    = err_cnt_q + 9'd1;
          first_fail_d = 1'b1;
          if (!first_fail_q) begin
            fail_vec_d = vec_q;
          end
        end
`ifdef TESTER_STOP_ON_FAIL_EN
        if (mismatch || (vec_q == 8'hFF)) begin
          state_d = S_FIN;
        end else begin
          state_d = S_SETTLE;
          vec_d   = vec_q + 8'd1;
          cnt_d   = SETTLE_LD;
        end
`else
        if (vec_q == 8'hFF) begin
          state_d = S_FIN;
        end else begin
          state_d = S_SETTLE;
          vec_d   = vec_q + 8'd1;
          cnt_d   = SETTLE_LD;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are decoded from the next state so they are registered alongside it
    busy_d = (state_d == S_SETTLE) || (state_d == S_CHECK);
    done_d = (state_d == S_FIN);
    pass_d = done_d && (err_cnt_d == 9'd0);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      vec_q        <= 8'h00;
      cnt_q        <= 4'd0;
      err_cnt_q    <= 9'd0;
      fail_vec_q   <= 8'h00;
      first_fail_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      err_cnt_q    <= err_cnt_d;
      fail_vec_q   <= fail_vec_d;
      first_fail_q <= first_fail_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign A        = vec_q[7:4];
  assign B        = vec_q[3:0];
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign ERR_CNT  = err_cnt_q;
  assign FAIL_VEC = fail_vec_q;

endmodule

// File: doc/and_gate_tester.md
AND_GATE_TESTER -- requirements
Module: and_gate_tester

Interface
REQ-001 Parameter SETTLE, default 2: number of wait cycles between driving a vector and sampling Y; legal range 1..15.
REQ-002 Clocking: one clock, CLK, rising edge; reset is synchronous and active-low, RST_N.
REQ-003 CLK  input  1  system clock.
REQ-004 RST_N  input  1  synchronous active-low reset.
REQ-005 START  input  1  level request; starts a sweep when sampled high in IDLE or FIN.
REQ-006 A  output  4  stimulus operand A to the quad 2-input AND gate under test, registered.
REQ-007 B  output  4  stimulus operand B to the gate under test, registered.
REQ-008 Y  input  4  gate-under-test response, sampled only in CHECK.
REQ-009 BUSY  output  1  high while in SETTLE or CHECK.
REQ-010 DONE  output  1  high while in FIN.
REQ-011 PASS  output  1  DONE and ERR_CNT==0; low otherwise.
REQ-012 ERR_CNT  output  9  number of mismatching vectors in the last or current sweep.
REQ-013 FAIL_VEC  output  8  {A,B} of the first mismatching vector; 0 if none.

Function
REQ-014 The FSM SHALL have states IDLE, SETTLE, CHECK and FIN, with registered outputs only.
REQ-015 IDLE/FIN with START=1 -> SETTLE; vec<=0 (A=0, B=0); wait counter<=SETTLE; ERR_CNT<=0; FAIL_VEC<=0; first-fail flag cleared.
REQ-016 SETTLE: counter decrements each cycle; at counter==1 -> CHECK; A/B held.
REQ-017 CHECK (one cycle): mismatch = (Y != (A & B)); on mismatch ERR_CNT+1, and FAIL_VEC<={A,B} if first-fail flag clear, then set flag.
REQ-018 CHECK with vec!=8'hFF -> SETTLE; vec<=vec+1, where {A,B}=vec and A is the upper nibble; counter reloaded to SETTLE.
REQ-019 CHECK with vec==8'hFF -> FIN; vec does not wrap; A/B hold 4'hF.
REQ-020 Each vector SHALL take SETTLE+1 cycles, so a full sweep has DONE rising 256*(SETTLE+1) edges after the START-sampling edge.
REQ-021 START in SETTLE or CHECK SHALL be ignored; START held high in FIN SHALL restart immediately (REQ-015).
REQ-022 ERR_CNT SHALL never exceed 256, so the 9-bit width needs no saturation.
REQ-023 FIN SHALL hold DONE, PASS, ERR_CNT and FAIL_VEC stable until the next START.

Reset
REQ-024 RST_N low at a rising edge SHALL force the state to IDLE and set A=0, B=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_VEC=0 and the first-fail flag to 0, including mid-sweep.
REQ-025 After reset release, no sweep SHALL start until START is sampled high.

Configuration
REQ-026 Macro TESTER_STOP_ON_FAIL_EN, when defined, SHALL make the first mismatch in CHECK go directly to FIN, leaving ERR_CNT=1 and FAIL_VEC equal to the failing vector.
REQ-027 With TESTER_STOP_ON_FAIL_EN undefined, every sweep SHALL cover all 256 vectors regardless of mismatches.

Verification
REQ-028 Ideal combinational AND model on Y, SETTLE=2, START pulse -> DONE after 768 cycles, PASS=1, ERR_CNT=0, FAIL_VEC=0.
REQ-029 Y[2] stuck at 0, macro undefined -> ERR_CNT=64, FAIL_VEC=8'h44, PASS=0, DONE after 768 cycles.
REQ-030 Same fault, TESTER_STOP_ON_FAIL_EN defined -> DONE 207 cycles after START (69 vectors x 3), ERR_CNT=1, FAIL_VEC=8'h44.
REQ-031 RST_N low for 1 cycle at cycle 100 of a sweep -> all outputs 0 the next cycle; a later START sweeps again from vec 0 with full 768-cycle duration.
REQ-032 START held high for the whole run with an ideal gate -> re-pulses on BUSY ignored; DONE high for exactly 1 cycle, then a new sweep starts with ERR_CNT cleared.
